// File: rtl/sd4_operand_loader_if.sv
// Operand-loader bus for the SD4 MAC front end: weight stream, pixel stream
// and the registered window/kernel/bias bundle with its valid/ready handshake.
interface sd4_operand_loader_if #(
  parameter int PIX_W = 8,
  parameter int WGT_W = 4,
  parameter int TAPS  = 9
);
  logic [WGT_W-1:0]      wgt_in;
  logic                  wgt_valid;
  logic                  wgt_ready;
  logic                  wgt_reload;
  logic [PIX_W-1:0]      pix_in;
  logic                  pix_valid;
  logic                  pix_ready;
  logic                  frame_start;
  logic [4:0]            exp_bias_cfg;
  logic [PIX_W*TAPS-1:0] image_out;
  logic [WGT_W*TAPS-1:0] weight_out;
  logic [4:0]            exp_bias_out;
  logic                  out_valid;
  logic                  out_ready;
  logic [15:0]           win_cnt;

  modport master (
    output wgt_in, wgt_valid, wgt_reload, pix_in, pix_valid, frame_start,
           exp_bias_cfg, out_ready,
    input  wgt_ready, pix_ready, image_out, weight_out, exp_bias_out,
           out_valid, win_cnt
  );

  modport slave (
    input  wgt_in, wgt_valid, wgt_reload, pix_in, pix_valid, frame_start,
           exp_bias_cfg, out_ready,
    output wgt_ready, pix_ready, image_out, weight_out, exp_bias_out,
           out_valid, win_cnt
  );
endinterface

// File: rtl/sd4_operand_loader.sv
// SD4 operand loader: 9-weight kernel capture plus 3x3 pixel window assembly.
// Optional SD4_LOADER_SLIDE_EN enables horizontal sliding-window reuse.
module sd4_operand_loader #(
  parameter int PIX_W = 8,
  parameter int WGT_W = 4
) (
  input logic clk,
  input logic rst,
  sd4_operand_loader_if.slave bus
);
  localparam int TAPS = 9;

  typedef enum logic {WLOAD, RUN} state_t;

  state_t                state_q, state_d;
  logic [3:0]            wcnt_q;
  logic [3:0]            cnt_q;
  logic [WGT_W-1:0]      kern_q [TAPS];
  logic [PIX_W-1:0]      buf_q  [TAPS];
  logic [PIX_W*TAPS-1:0] image_q;
  logic [PIX_W*TAPS-1:0] img_next;
  logic [4:0]            bias_q;
  logic                  out_valid_q;
  logic [15:0]           win_cnt_q;
  logic                  reload_pend_q;
  logic                  wgt_ready, pix_ready;
  logic                  wgt_fire, pix_fire, emit, slot_free, to_wload;
  logic [3:0]            last_idx;

`ifdef SD4_LOADER_SLIDE_EN
  logic warm_q, win_warm_q, frame_pend_q, start_warm;
  // A window starts warm only if no frame_start is pending or arriving now.
  assign start_warm = warm_q & ~frame_pend_q & ~bus.frame_start;
  assign last_idx   = win_warm_q ? 4'd2 : 4'd8;
`else
  assign last_idx   = 4'd8;
`endif

  assign slot_free = ~out_valid_q | bus.out_ready;
  assign wgt_fire  = (state_q == WLOAD) & bus.wgt_valid;
  assign pix_fire  = bus.pix_valid & pix_ready;
  assign emit      = pix_fire & (cnt_q == last_idx);
  assign to_wload  = (state_q == RUN) & (state_d == WLOAD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= WLOAD;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WLOAD:   if (wgt_fire && wcnt_q == 4'd8) state_d = RUN;
      RUN:     if (reload_pend_q && cnt_q == 4'd0 && !out_valid_q) state_d = WLOAD;
      default: state_d = WLOAD;
    endcase
  end

  always_comb begin
    wgt_ready = 1'b0;
    pix_ready = 1'b0;
    case (state_q)
      WLOAD:   wgt_ready = 1'b1;
      RUN:     pix_ready = !(reload_pend_q && cnt_q == 4'd0) &&
                           !(cnt_q == last_idx && !slot_free);
      default: ;
    endcase
  end

  // The closing pixel of every window lands in tap 8, in both load modes.
  always_comb begin
    img_next = '0;
    for (int k = 0; k < TAPS - 1; k++)
      img_next[PIX_W*(TAPS-k)-1 -: PIX_W] = buf_q[k];
    img_next[PIX_W-1:0] = bus.pix_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt_q        <= '0;
      cnt_q         <= '0;
      image_q       <= '0;
      bias_q        <= '0;
      out_valid_q   <= 1'b0;
      win_cnt_q     <= '0;
      reload_pend_q <= 1'b0;
      for (int k = 0; k < TAPS; k++) begin
        kern_q[k] <= '0;
        buf_q[k]  <= '0;
      end
`ifdef SD4_LOADER_SLIDE_EN
      warm_q       <= 1'b0;
      win_warm_q   <= 1'b0;
      frame_pend_q <= 1'b0;
`endif
    end else begin
      if (wgt_fire) begin
        kern_q[wcnt_q] <= bus.wgt_in;
        wcnt_q         <= (wcnt_q == 4'd8) ? 4'd0 : wcnt_q + 4'd1;
      end

      if (to_wload)
        reload_pend_q <= 1'b0;
      else if (state_q == RUN && bus.wgt_reload)
        reload_pend_q <= 1'b1;

      if (pix_fire) begin
        cnt_q <= emit ? 4'd0 : cnt_q + 4'd1;
`ifdef SD4_LOADER_SLIDE_EN
        if (cnt_q == 4'd0 && start_warm) begin
          for (int r = 0; r < 3; r++) begin
            buf_q[3*r]   <= buf_q[3*r+1];
            buf_q[3*r+1] <= buf_q[3*r+2];
          end
          buf_q[2]   <= bus.pix_in;
          win_warm_q <= 1'b1;
        end else if (cnt_q == 4'd0) begin
          buf_q[0]   <= bus.pix_in;
          win_warm_q <= 1'b0;
        end else if (win_warm_q) begin
          if (cnt_q == 4'd1) buf_q[5] <= bus.pix_in;
          else               buf_q[8] <= bus.pix_in;
        end else begin
          buf_q[cnt_q] <= bus.pix_in;
        end
`else
        buf_q[cnt_q] <= bus.pix_in;
`endif
      end

`ifdef SD4_LOADER_SLIDE_EN
      if (to_wload) begin
        warm_q       <= 1'b0;
        frame_pend_q <= 1'b0;
      end else begin
        if (emit) warm_q <= 1'b1;
        if (pix_fire && cnt_q == 4'd0) frame_pend_q <= 1'b0;
        else if (bus.frame_start)      frame_pend_q <= 1'b1;
      end
`endif

      if (emit) begin
        image_q     <= img_next;
        bias_q      <= bus.exp_bias_cfg;
        out_valid_q <= 1'b1;
        win_cnt_q   <= win_cnt_q + 16'd1;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  for (genvar k = 0; k < TAPS; k++) begin : g_kern
    assign bus.weight_out[WGT_W*(TAPS-k)-1 -: WGT_W] = kern_q[k];
  end

  assign bus.wgt_ready    = wgt_ready;
  assign bus.pix_ready    = pix_ready;
  assign bus.image_out    = image_q;
  assign bus.exp_bias_out = bias_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.win_cnt      = win_cnt_q;
endmodule

// File: tb/tb_sd4_operand_loader.sv
// Scoreboard bench for sd4_operand_loader: window-level reference model feeds
// an expected-bundle queue that a separate monitor drains on each handshake.
module tb_sd4_operand_loader;
  logic clk = 1'b0;
  logic rst;
  logic rand_ready, oready_rand, oready_dir;

  always #5 clk = ~clk;

  sd4_operand_loader_if bus ();

  sd4_operand_loader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.out_ready = rand_ready ? oready_rand : oready_dir;

  typedef struct {
    logic [71:0] img;
    logic [35:0] wgt;
    logic [4:0]  bias;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  int pass_cnt  = 0;
  int check_cnt = 0;

  logic [7:0] m_win  [9];
  logic [7:0] m_col  [3];
  logic [3:0] m_kern [9];
  int m_pos, m_kidx, m_wins;
  bit m_warm, m_frame, m_cur_warm;

  task automatic checkOutput(input string name, input logic [71:0] act, input logic [71:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    check_cnt++;
    $display("[TB] FAIL %s: bound expired", name);
  endtask

  function automatic logic [71:0] pack_img();
    logic [71:0] r = '0;
    for (int k = 0; k < 9; k++) r[71-8*k -: 8] = m_win[k];
    return r;
  endfunction

  function automatic logic [35:0] pack_kern();
    logic [35:0] r = '0;
    for (int k = 0; k < 9; k++) r[35-4*k -: 4] = m_kern[k];
    return r;
  endfunction

  task automatic model_reset();
    m_pos = 0; m_kidx = 0; m_wins = 0; m_warm = 0; m_frame = 0; m_cur_warm = 0;
    for (int k = 0; k < 9; k++) begin m_kern[k] = '0; m_win[k] = '0; end
    sb.delete();
  endtask

  task automatic model_emit();
    exp_t e;
    m_wins++;
    e.img  = pack_img();
    e.wgt  = pack_kern();
    e.bias = bus.exp_bias_cfg;
    e.cnt  = m_wins[15:0];
    sb.push_back(e);
    m_pos  = 0;
    m_warm = 1;
  endtask

  // Warm windows collect a fresh column of three, then slide the window left.
  task automatic model_pix(input logic [7:0] p);
    if (m_pos == 0) begin
`ifdef SD4_LOADER_SLIDE_EN
      m_cur_warm = m_warm && !m_frame;
      m_frame    = 0;
`else
      m_cur_warm = 0;
`endif
    end
    if (m_cur_warm) begin
      m_col[m_pos] = p;
      m_pos++;
      if (m_pos == 3) begin
        for (int r = 0; r < 3; r++) begin
          m_win[3*r]   = m_win[3*r+1];
          m_win[3*r+1] = m_win[3*r+2];
          m_win[3*r+2] = m_col[r];
        end
        model_emit();
      end
    end else begin
      m_win[m_pos] = p;
      m_pos++;
      if (m_pos == 9) model_emit();
    end
  endtask

  task automatic applyStimulus(input bit is_wgt, input logic [7:0] d);
    int n = 0;
    if (is_wgt) begin bus.wgt_in = d[3:0]; bus.wgt_valid = 1'b1; end
    else        begin bus.pix_in = d;      bus.pix_valid = 1'b1; end
    #1;
    while (!(is_wgt ? bus.wgt_ready : bus.pix_ready) && n < 300) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 300) begin
      fail_now(is_wgt ? "wgt_accept" : "pix_accept");
    end else begin
      @(posedge clk);
      if (is_wgt) begin m_kern[m_kidx] = d[3:0]; m_kidx = (m_kidx + 1) % 9; end
      else model_pix(d);
    end
    @(negedge clk);
    bus.wgt_valid = 1'b0;
    bus.pix_valid = 1'b0;
  endtask

  task automatic reload_weights();
    int n = 0;
    #1;
    while (!bus.wgt_ready && n < 300) begin @(negedge clk); #1; n++; end
    if (n >= 300) fail_now("enter_wload");
    m_warm = 0; m_frame = 0; m_kidx = 0;
    for (int k = 0; k < 9; k++) applyStimulus(1'b1, 8'($urandom_range(0, 15)));
  endtask

  task automatic check_reset_outputs(input string tag);
    checkOutput({tag, "_out_valid"}, bus.out_valid, 0);
    checkOutput({tag, "_image"}, bus.image_out, 0);
    checkOutput({tag, "_weight"}, bus.weight_out, 0);
    checkOutput({tag, "_bias"}, bus.exp_bias_out, 0);
    checkOutput({tag, "_win_cnt"}, bus.win_cnt, 0);
    checkOutput({tag, "_wgt_ready"}, bus.wgt_ready, 1);
    checkOutput({tag, "_pix_ready"}, bus.pix_ready, 0);
  endtask

  // Monitor: every accepted bundle must match the oldest expected one.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #1;
      if (!rst && bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check_cnt++;
          $display("[TB] FAIL unexpected_bundle: got image %0h, expected none", bus.image_out);
        end else begin
          e = sb.pop_front();
          checkOutput("sb_image", bus.image_out, e.img);
          checkOutput("sb_weight", bus.weight_out, e.wgt);
          checkOutput("sb_bias", bus.exp_bias_out, e.bias);
          checkOutput("sb_win_cnt", bus.win_cnt, e.cnt);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      oready_rand = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n, sent;
    bit do_reload;
    rst = 1'b1; rand_ready = 1'b0; oready_rand = 1'b0; oready_dir = 1'b0;
    bus.wgt_in = '0; bus.wgt_valid = 1'b0; bus.wgt_reload = 1'b0;
    bus.pix_in = '0; bus.pix_valid = 1'b0; bus.frame_start = 1'b0;
    bus.exp_bias_cfg = '0;
    model_reset();
    repeat (3) @(negedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    oready_dir = 1'b1;

    $display("[TB] kernel load 1..9");
    for (int k = 1; k <= 9; k++) applyStimulus(1'b1, 8'(k));
    #1;
    checkOutput("kernel", bus.weight_out, 36'h123456789);
    checkOutput("wgt_ready_after_load", bus.wgt_ready, 0);
    checkOutput("pix_ready_after_load", bus.pix_ready, 1);

    $display("[TB] first window");
    bus.exp_bias_cfg = 5'd7;
    for (int k = 1; k <= 9; k++) applyStimulus(1'b0, 8'(k));
    #1;
    checkOutput("emit_latency", bus.out_valid, 1);
    checkOutput("first_image", bus.image_out, 72'h010203040506070809);
    checkOutput("first_bias", bus.exp_bias_out, 7);
    checkOutput("first_win_cnt", bus.win_cnt, 1);

    $display("[TB] back-pressure");
    @(negedge clk);
    oready_dir = 1'b0;
    bus.exp_bias_cfg = 5'd12;
    for (int k = 1; k <= 9; k++) applyStimulus(1'b0, 8'(8'h10 + k));
    for (int k = 1; k <= 8; k++) applyStimulus(1'b0, 8'(8'h20 + k));
    bus.exp_bias_cfg = 5'd3;
    bus.pix_in = 8'h29; bus.pix_valid = 1'b1;
    #1;
    checkOutput("stall_pix_ready", bus.pix_ready, 0);
    checkOutput("stall_image", bus.image_out, 72'h111213141516171819);
    repeat (2) @(negedge clk);
    #1;
    checkOutput("stall_hold_valid", bus.out_valid, 1);
    checkOutput("stall_hold_image", bus.image_out, 72'h111213141516171819);
    checkOutput("stall_hold_bias", bus.exp_bias_out, 12);
    @(negedge clk);
    oready_dir = 1'b1;
    applyStimulus(1'b0, 8'h29);
    #1;
    checkOutput("replace_valid", bus.out_valid, 1);
    checkOutput("replace_image", bus.image_out, 72'h212223242526272829);

    $display("[TB] reload mid-window");
    for (int k = 0; k < 4; k++) applyStimulus(1'b0, 8'($urandom));
    bus.wgt_reload = 1'b1;
    @(negedge clk);
    bus.wgt_reload = 1'b0;
    for (int k = 0; k < 5; k++) applyStimulus(1'b0, 8'($urandom));
    #1;
    checkOutput("reload_window_emitted", bus.out_valid, 1);
    checkOutput("reload_pix_block", bus.pix_ready, 0);
    n = 0;
    while (!bus.wgt_ready && n < 20) begin @(negedge clk); #1; n++; end
    checkOutput("reload_wload", bus.wgt_ready, 1);
    checkOutput("reload_wload_pix", bus.pix_ready, 0);
    reload_weights();
    #1;
    checkOutput("reload_kernel", bus.weight_out, pack_kern());
    checkOutput("reload_run", bus.pix_ready, 1);

    $display("[TB] reset mid-window");
    @(negedge clk);
    oready_dir = 1'b0;
    for (int k = 0; k < 14; k++) applyStimulus(1'b0, 8'($urandom));
    rst = 1'b1;
    #1 check_reset_outputs("midreset");
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    oready_dir = 1'b1;
    reload_weights();

    $display("[TB] slide / frame_start");
    for (int k = 1; k <= 9; k++) applyStimulus(1'b0, 8'(k));
`ifdef SD4_LOADER_SLIDE_EN
    for (int k = 10; k <= 12; k++) applyStimulus(1'b0, 8'(k));
    #1;
    checkOutput("slide_image", bus.image_out, 72'h02030A05060B08090C);
    @(negedge clk);
`endif
    bus.frame_start = 1'b1; m_frame = 1;
    @(negedge clk);
    bus.frame_start = 1'b0;
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 8'($urandom));
    #1;
    checkOutput("frame_full_reload", bus.out_valid, 0);
    for (int k = 0; k < 6; k++) applyStimulus(1'b0, 8'($urandom));

    $display("[TB] random traffic");
    rand_ready = 1'b1;
    for (int w = 0; w < 40; w++) begin
      do_reload = ($urandom_range(0, 7) == 0);
      sent = 0;
      do begin
        bus.exp_bias_cfg = 5'($urandom);
        applyStimulus(1'b0, 8'($urandom));
        sent++;
        if (do_reload && sent == 2) begin
          bus.wgt_reload = 1'b1;
          @(negedge clk);
          bus.wgt_reload = 1'b0;
        end
        if ($urandom_range(0, 9) == 0) begin
          bus.frame_start = 1'b1; m_frame = 1;
          @(negedge clk);
          bus.frame_start = 1'b0;
        end
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end while (m_pos != 0 && sent < 20);
      if (do_reload) reload_weights();
    end

    @(negedge clk);
    rand_ready = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 50) begin @(negedge clk); n++; end
    checkOutput("sb_drained", sb.size(), 0);
    repeat (2) @(negedge clk);
    #1 checkOutput("final_out_valid", bus.out_valid, 0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule
